// File: rtl/imm_exec_sequencer.sv
// imm_exec_sequencer: fetch/decode/execute/writeback control FSM for the register-immediate
// and register-register ALU path, trapping on unsupported opcodes or illegal ALU decodes.
module imm_exec_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [4:0]  ALU_NOP_CODE = 5'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_q,
    input  logic [4:0]  alu_control,
    output logic        alu_en,
    output logic        alu_src_imm,
    output logic        res_capture,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic        retired,
    output logic        trap,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

    state_t state;
    logic   legal;

    assign imem_addr = pc;
    assign legal = (instr_q[6:0] == 7'h13 || instr_q[6:0] == 7'h33) && alu_control != ALU_NOP_CODE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr_q     <= '0;
            imem_req    <= 1'b0;
            alu_en      <= 1'b0;
            alu_src_imm <= 1'b0;
            res_capture <= 1'b0;
            rf_we       <= 1'b0;
            retired     <= 1'b0;
            trap        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            alu_en      <= 1'b0;
            res_capture <= 1'b0;
            rf_we       <= 1'b0;
            retired     <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                    busy     <= 1'b1;
                end
                FETCH: if (imem_ack) begin
                    instr_q  <= imem_rdata;
                    imem_req <= 1'b0;
                    state    <= DECODE;
                end
                DECODE: if (legal) begin
                    state       <= EXEC;
                    alu_en      <= 1'b1;
                    res_capture <= 1'b1;
                    alu_src_imm <= instr_q[6:0] == 7'h13;
                end else begin
                    state <= HALT;
                    trap  <= 1'b1;
                    busy  <= 1'b0;
                end
                EXEC: begin
                    state   <= WB;
                    rf_we   <= instr_q[11:7] != 5'd0;
                    retired <= 1'b1;
                end
                WB: begin
                    pc       <= pc + 32'd4;
                    state    <= start ? FETCH : IDLE;
                    imem_req <= start;
                    busy     <= start;
                end
                HALT: if (start) begin
                    // resume past the faulting instruction
                    trap     <= 1'b0;
                    pc       <= pc + 32'd4;
                    state    <= FETCH;
                    imem_req <= 1'b1;
                    busy     <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imm_exec_sequencer.sv
// tb_imm_exec_sequencer: table-driven directed checks of the sequencer, plus reset,
// held-start and PC-wrap sequences on a second instance with RESET_PC = 32'hFFFF_FFFC.
module tb_imm_exec_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, start, imem_ack;
    logic [31:0] imem_rdata;
    logic [4:0]  alu_control;
    logic        imem_req, alu_en, alu_src_imm, res_capture, rf_we, retired, trap, busy;
    logic [31:0] imem_addr, instr_q, pc;
    logic        imem_req2, alu_en2, alu_src_imm2, res_capture2, rf_we2, retired2, trap2, busy2;
    logic [31:0] imem_addr2, instr_q2, pc2;

    always #5 clk = ~clk;

    imm_exec_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_q(instr_q), .alu_control(alu_control),
        .alu_en(alu_en), .alu_src_imm(alu_src_imm), .res_capture(res_capture), .rf_we(rf_we),
        .pc(pc), .retired(retired), .trap(trap), .busy(busy)
    );

    imm_exec_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_q(instr_q2), .alu_control(alu_control),
        .alu_en(alu_en2), .alu_src_imm(alu_src_imm2), .res_capture(res_capture2), .rf_we(rf_we2),
        .pc(pc2), .retired(retired2), .trap(trap2), .busy(busy2)
    );

    typedef struct {
        logic [31:0] rd;
        logic [4:0]  ac;
        int          w;
        logic        legal;
        logic        we;
        logic        imm;
    } vec_t;

    vec_t        vecs[7];
    int          total = 0;
    int          passed = 0;
    logic [31:0] exp_pc = 32'h0;
    logic        halted = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic launch();
        if (halted) begin
            exp_pc += 32'd4;
            halted = 1'b0;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("trap_cleared", trap, 0);
    endtask

    // entered at the negedge of the first FETCH cycle
    task automatic body(input vec_t v, input logic hold);
        imem_rdata  = v.rd;
        alu_control = v.ac;
        for (int i = 0; i < v.w; i++) begin
            chk("req_wait", imem_req, 1);
            chk("addr_wait", imem_addr, exp_pc);
            @(negedge clk);
        end
        chk("req", imem_req, 1);
        chk("addr", imem_addr, exp_pc);
        chk("busy_fetch", busy, 1);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("instr_q", instr_q, v.rd);
        chk("req_drop", imem_req, 0);
        chk("alu_en_decode", alu_en, 0);
        @(negedge clk);
        if (v.legal) begin
            chk("alu_en", alu_en, 1);
            chk("res_capture", res_capture, 1);
            chk("src_imm", alu_src_imm, v.imm);
            chk("rf_we_exec", rf_we, 0);
            chk("trap_legal", trap, 0);
            @(negedge clk);
            chk("rf_we", rf_we, v.we);
            chk("retired", retired, 1);
            chk("alu_en_wb", alu_en, 0);
            chk("src_imm_wb", alu_src_imm, v.imm);
            chk("pc_wb", pc, exp_pc);
            start = hold;
            @(negedge clk);
            start = 1'b0;
            exp_pc += 32'd4;
            chk("pc_next", pc, exp_pc);
            chk("retired_drop", retired, 0);
            chk("req_next", imem_req, hold);
            chk("busy_next", busy, hold);
        end else begin
            chk("trap", trap, 1);
            chk("alu_en_trap", alu_en, 0);
            chk("busy_halt", busy, 0);
            chk("pc_halt", pc, exp_pc);
            repeat (2) @(negedge clk);
            chk("trap_sticky", trap, 1);
            chk("pc_frozen", pc, exp_pc);
            chk("retired_halt", retired, 0);
            halted = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0050_0093, 5'h01, 0, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{32'h0010_0013, 5'h01, 0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h0020_81b3, 5'h01, 3, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{32'h4010_9093, 5'h00, 0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0063, 5'h01, 1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h0050_0093, 5'h01, 3, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{32'h4020_8133, 5'h02, 1, 1'b1, 1'b1, 1'b0};
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0; alu_control = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_req", imem_req, 0);
        end
        chk("reset_pc", pc, 32'h0);
        chk("reset_pc_wrap", pc2, 32'hFFFF_FFFC);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("req_before_reset", imem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req_drop", imem_req, 0);
        chk("async_pc", pc, 32'h0);
        chk("async_trap", trap, 0);
        chk("async_busy", busy, 0);
        imem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("late_ack_req", imem_req, 0);
        chk("late_ack_busy", busy, 0);
        chk("late_ack_instr", instr_q, 32'h0);
        for (int i = 0; i < 7; i++) begin
            launch();
            body(vecs[i], 1'b0);
            if (i == 0) chk("pc_wrap", pc2, 32'h0);
        end
        launch();
        body(vecs[0], 1'b1);
        body(vecs[1], 1'b0);
        chk("wrap_tracks", pc2, exp_pc - 32'd4);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
